motor_mixer: RTL and testbench
==============================

MOTOR_MIXER -- requirements
Module: motor_mixer

Interface
REQ-001 SHALL have parameter SPEED_MIN, default 16'd16384, floor applied to every armed motor speed.
REQ-002 SHALL have parameter SPEED_MAX, default 16'd60000, ceiling applied to every armed motor speed.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 32'd1_000_000, idle cycles while armed before failsafe.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port throttle  input  16  unsigned base speed.
REQ-007 SHALL have ports roll, pitch, yaw  input  16 each  signed two's-complement corrections.
REQ-008 SHALL have port arm  input  1  sampled with command; 0 forces all speeds to 0.
REQ-009 SHALL have port cmd_valid  input  1  command present.
REQ-010 SHALL have port cmd_ready  output  1  high only in IDLE; transfer on cmd_valid & cmd_ready.
REQ-011 SHALL have ports speed_out0..speed_out3  output  16 each  per-motor speed, drives pwm speed_in.
REQ-012 SHALL have port speed_oe  output  4  per-motor one-cycle load strobe, drives pwm speed_oe.
REQ-013 SHALL have port pwm_busy  input  4  busy flags from the four pwm channels.
REQ-014 SHALL have port failsafe  output  1  high after timeout-issued update until next accepted command.

Function
REQ-015 SHALL implement FSM IDLE -> MIX -> CLAMP -> WAIT -> ISSUE -> IDLE, one state per cycle except WAIT.
REQ-016 SHALL latch throttle, roll, pitch, yaw, arm in the acceptance cycle; inputs are ignored outside IDLE.
REQ-017 SHALL in MIX compute in 19-bit signed (throttle zero-extended, corrections sign-extended): m0=T+P+R-Y, m1=T+P-R+Y, m2=T-P-R-Y, m3=T-P+R+Y.
REQ-018 SHALL in CLAMP saturate each m to [SPEED_MIN, SPEED_MAX] when armed, and force 0 when disarmed.
REQ-019 SHALL remain in WAIT while pwm_busy != 4'b0000, holding clamped values, without timeout.
REQ-020 SHALL on the edge leaving WAIT load speed_out0..3 from clamped values and set speed_oe=4'b1111 for exactly one cycle (ISSUE).
REQ-021 SHALL keep speed_out0..3 stable at all times except the ISSUE load edge.
REQ-022 SHALL give minimum latency 3 cycles: acceptance edge E0, speed_oe high after E3, cmd_ready high again after E4.
REQ-023 SHALL count consecutive IDLE cycles with arm_latched=1 and no acceptance; counter cleared on acceptance.
REQ-024 SHALL on counter reaching TIMEOUT_CYC enter MIX with internal command T=SPEED_MIN, R=P=Y=0, armed, and set failsafe=1.
REQ-025 SHALL give cmd_valid priority over timeout in the same cycle: command accepted, counter cleared, no failsafe.
REQ-026 SHALL clear failsafe on the next accepted external command.
REQ-027 SHALL never assert speed_oe outside ISSUE.

Reset
REQ-028 SHALL on rst_n=0 immediately force state IDLE, speed_out0..3=0, speed_oe=0, failsafe=0, counter=0, arm_latched=0.
REQ-029 SHALL drive cmd_ready=1 from the first cycle after rst_n deasserts.
REQ-030 SHALL abandon any in-flight command on reset mid-operation, with no speed_oe pulse afterward.

Structure
REQ-031 SHALL place SPEED_W=16, MIX_W=19, state enum, and per-motor sign table (P,R,Y signs) in shared package quad_pkg.
REQ-032 SHALL instantiate sub-module mix_sat four times (one per motor): signed sum plus saturation, combinational, registered by motor_mixer.

Verification
REQ-033 SHALL cover nominal mix: T=30000, R=+1000, P=-500, Y=+200, armed, busy=0 -> speed_out = 30300/28700/29300/31700, speed_oe=4'b1111 for 1 cycle, 3 cycles after acceptance.
REQ-034 SHALL cover saturation: T=59000, P=+2000, R=Y=0 -> 60000/60000/57000/57000; T=0, R=-5000 -> m0=16384, m1=16384 (clamped up from 5000), m2=16384, m3=16384.
REQ-035 SHALL cover disarm and backpressure: arm=0, T=40000 -> all speeds 0; pwm_busy=4'b0100 held 50 cycles -> speed_oe stays 0, pulses 1 cycle after busy clears.
REQ-036 SHALL cover failsafe with TIMEOUT_CYC=100: armed command, then no cmd_valid for 100 cycles -> all speeds 16384, failsafe=1; next command clears failsafe; cmd_valid in expiry cycle -> failsafe stays 0.
REQ-037 SHALL cover reset mid-operation: rst_n low during WAIT -> outputs zero immediately, no subsequent speed_oe, cmd_ready=1 after release.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared widths, FSM state encoding and per-motor mixing sign table for the quad motor mixer.
package quad_pkg;

    localparam int unsigned SPEED_W = 16;
    localparam int unsigned MIX_W   = 19;
    localparam int unsigned N_MOTOR = 4;
    localparam int unsigned CNT_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MIX   = 3'd1,
        ST_CLAMP = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ISSUE = 3'd4
    } state_e;

    // Per-motor subtract flags {pitch, roll, yaw}; a set bit means that correction is subtracted.
    //   m0 = T+P+R-Y, m1 = T+P-R+Y, m2 = T-P-R-Y, m3 = T-P+R+Y
    localparam logic [N_MOTOR-1:0][2:0] SIGN_TAB = {3'b100, 3'b111, 3'b010, 3'b001};

    typedef struct packed {
        logic [SPEED_W-1:0] throttle;
        logic [SPEED_W-1:0] roll;
        logic [SPEED_W-1:0] pitch;
        logic [SPEED_W-1:0] yaw;
    } cmd_t;

endpackage

// File: rtl/mix_sat.sv
// One motor's mixing sum and armed-speed saturation; purely combinational, registered by the parent.
module mix_sat
    import quad_pkg::*;
#(
    parameter logic [SPEED_W-1:0] SPEED_MIN = 16'd16384,
    parameter logic [SPEED_W-1:0] SPEED_MAX = 16'd60000,
    parameter logic [2:0]         SIGNS     = 3'b000
) (
    input  logic [SPEED_W-1:0] throttle,
    input  logic [SPEED_W-1:0] roll,
    input  logic [SPEED_W-1:0] pitch,
    input  logic [SPEED_W-1:0] yaw,
    input  logic [MIX_W-1:0]   mix_in,
    input  logic               arm,
    output logic [MIX_W-1:0]   mix_c,
    output logic [SPEED_W-1:0] sat_c
);

    localparam logic signed [MIX_W-1:0] LO = $signed(MIX_W'(SPEED_MIN));
    localparam logic signed [MIX_W-1:0] HI = $signed(MIX_W'(SPEED_MAX));

    logic signed [MIX_W-1:0] t_x;
    logic signed [MIX_W-1:0] r_x;
    logic signed [MIX_W-1:0] p_x;
    logic signed [MIX_W-1:0] y_x;
    logic signed [MIX_W-1:0] acc;
    logic signed [MIX_W-1:0] mix_s;

    // Throttle is unsigned base speed; corrections are two's complement.
    assign t_x   = $signed(MIX_W'(throttle));
    assign r_x   = MIX_W'($signed(roll));
    assign p_x   = MIX_W'($signed(pitch));
    assign y_x   = MIX_W'($signed(yaw));
    assign mix_s = $signed(mix_in);

    always_comb begin
        acc = t_x;
        acc = SIGNS[2] ? (acc - p_x) : (acc + p_x);
        acc = SIGNS[1] ? (acc - r_x) : (acc + r_x);
        acc = SIGNS[0] ? (acc - y_x) : (acc + y_x);
        mix_c = acc;
    end

    // Disarmed motors are stopped outright rather than held at the floor.
    always_comb begin
        sat_c = '0;
        if (!arm) begin
            sat_c = '0;
        end else if (mix_s < LO) begin
            sat_c = SPEED_MIN;
        end else if (mix_s > HI) begin
            sat_c = SPEED_MAX;
        end else begin
            sat_c = mix_in[SPEED_W-1:0];
        end
    end

endmodule

// File: rtl/motor_mixer.sv
// Quad motor mixer: accepts a throttle/attitude command, mixes and clamps four motor speeds,
// waits for the PWM channels to go idle, then loads them; falls back to a failsafe command on timeout.
module motor_mixer
    import quad_pkg::*;
#(
    parameter logic [SPEED_W-1:0] SPEED_MIN   = 16'd16384,
    parameter logic [SPEED_W-1:0] SPEED_MAX   = 16'd60000,
    parameter logic [CNT_W-1:0]   TIMEOUT_CYC = 32'd1_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SPEED_W-1:0] throttle,
    input  logic [SPEED_W-1:0] roll,
    input  logic [SPEED_W-1:0] pitch,
    input  logic [SPEED_W-1:0] yaw,
    input  logic               arm,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    output logic [SPEED_W-1:0] speed_out0,
    output logic [SPEED_W-1:0] speed_out1,
    output logic [SPEED_W-1:0] speed_out2,
    output logic [SPEED_W-1:0] speed_out3,
    output logic [N_MOTOR-1:0] speed_oe,
    input  logic [N_MOTOR-1:0] pwm_busy,
    output logic               failsafe
);

    state_e state;
    state_e state_d;

    cmd_t                             cmd_q;
    logic                             arm_latched;
    logic [CNT_W-1:0]                 idle_cnt;
    logic [N_MOTOR-1:0][MIX_W-1:0]    mix_q;
    logic [N_MOTOR-1:0][MIX_W-1:0]    mix_c;
    logic [N_MOTOR-1:0][SPEED_W-1:0]  sat_q;
    logic [N_MOTOR-1:0][SPEED_W-1:0]  sat_c;
    logic [N_MOTOR-1:0][SPEED_W-1:0]  speed_q;

    logic accept_c;
    logic timeout_c;
    logic issue_c;

    assign speed_out0 = speed_q[0];
    assign speed_out1 = speed_q[1];
    assign speed_out2 = speed_q[2];
    assign speed_out3 = speed_q[3];

    for (genvar i = 0; i < int'(N_MOTOR); i++) begin : g_motor
        mix_sat #(
            .SPEED_MIN (SPEED_MIN),
            .SPEED_MAX (SPEED_MAX),
            .SIGNS     (SIGN_TAB[i])
        ) u_mix_sat (
            .throttle (cmd_q.throttle),
            .roll     (cmd_q.roll),
            .pitch    (cmd_q.pitch),
            .yaw      (cmd_q.yaw),
            .mix_in   (mix_q[i]),
            .arm      (arm_latched),
            .mix_c    (mix_c[i]),
            .sat_c    (sat_c[i])
        );
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state; an external command beats a timeout that expires in the same cycle.
    always_comb begin
        state_d   = state;
        accept_c  = 1'b0;
        timeout_c = 1'b0;
        issue_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept_c = 1'b1;
                    state_d  = ST_MIX;
                end else if (arm_latched && (idle_cnt == (TIMEOUT_CYC - CNT_W'(1)))) begin
                    timeout_c = 1'b1;
                    state_d   = ST_MIX;
                end
            end
            ST_MIX:   state_d = ST_CLAMP;
            ST_CLAMP: state_d = ST_WAIT;
            ST_WAIT: begin
                if (pwm_busy == '0) begin
                    issue_c = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Command capture, failsafe flag and idle watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q       <= '0;
            arm_latched <= 1'b0;
            failsafe    <= 1'b0;
            idle_cnt    <= '0;
        end else begin
            if (accept_c) begin
                cmd_q.throttle <= throttle;
                cmd_q.roll     <= roll;
                cmd_q.pitch    <= pitch;
                cmd_q.yaw      <= yaw;
                arm_latched    <= arm;
                failsafe       <= 1'b0;
            end else if (timeout_c) begin
                cmd_q.throttle <= SPEED_MIN;
                cmd_q.roll     <= '0;
                cmd_q.pitch    <= '0;
                cmd_q.yaw      <= '0;
                arm_latched    <= 1'b1;
                failsafe       <= 1'b1;
            end

            if ((state == ST_IDLE) && !accept_c && !timeout_c && arm_latched) begin
                idle_cnt <= idle_cnt + CNT_W'(1);
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    // Mix/clamp pipeline and the output load; speed_out changes only on the ISSUE entry edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mix_q     <= '0;
            sat_q     <= '0;
            speed_q   <= '0;
            speed_oe  <= '0;
            cmd_ready <= 1'b1;
        end else begin
            if (state == ST_MIX) begin
                mix_q <= mix_c;
            end
            if (state == ST_CLAMP) begin
                sat_q <= sat_c;
            end
            if (issue_c) begin
                speed_q <= sat_q;
            end
            speed_oe  <= {N_MOTOR{issue_c}};
            cmd_ready <= (state_d == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_motor_mixer.sv
// Directed bench for motor_mixer with a transaction-level reference model checked every cycle.
module tb_motor_mixer;

    localparam int TMO  = 100;
    localparam int SMIN = 16384;
    localparam int SMAX = 60000;

    typedef logic [3:0][15:0] spd4_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] throttle = '0;
    logic [15:0] roll = '0;
    logic [15:0] pitch = '0;
    logic [15:0] yaw = '0;
    logic        arm = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] speed_out0;
    logic [15:0] speed_out1;
    logic [15:0] speed_out2;
    logic [15:0] speed_out3;
    logic [3:0]  speed_oe;
    logic [3:0]  pwm_busy = '0;
    logic        failsafe;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    motor_mixer #(
        .SPEED_MIN   (16'd16384),
        .SPEED_MAX   (16'd60000),
        .TIMEOUT_CYC (32'd100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .throttle   (throttle),
        .roll       (roll),
        .pitch      (pitch),
        .yaw        (yaw),
        .arm        (arm),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .speed_out0 (speed_out0),
        .speed_out1 (speed_out1),
        .speed_out2 (speed_out2),
        .speed_out3 (speed_out3),
        .speed_oe   (speed_oe),
        .pwm_busy   (pwm_busy),
        .failsafe   (failsafe)
    );

    always #5 clk = ~clk;

    // Motor speeds straight from the mixing equations with plain integer arithmetic.
    function automatic spd4_t mix(int t, int r, int p, int y, bit a);
        int    m[4];
        spd4_t s;
        m[0] = t + p + r - y;
        m[1] = t + p - r + y;
        m[2] = t - p - r - y;
        m[3] = t - p + r + y;
        for (int i = 0; i < 4; i++) begin
            if (!a)               s[i] = 16'(0);
            else if (m[i] < SMIN) s[i] = 16'(SMIN);
            else if (m[i] > SMAX) s[i] = 16'(SMAX);
            else                  s[i] = 16'(m[i]);
        end
        return s;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: age counts cycles since a command (external or failsafe) was taken, -1 when idle.
    int    age;
    int    m_cnt;
    bit    m_arm;
    bit    m_oe;
    bit    m_rdy;
    bit    m_fs;
    spd4_t pend;
    spd4_t m_spd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age   <= -1;
            m_cnt <= 0;
            m_arm <= 1'b0;
            m_oe  <= 1'b0;
            m_rdy <= 1'b1;
            m_fs  <= 1'b0;
            pend  <= '0;
            m_spd <= '0;
        end else begin
            m_oe <= 1'b0;
            if (age < 0) begin
                if (cmd_valid) begin
                    pend  <= mix(int'(throttle), int'($signed(roll)), int'($signed(pitch)),
                                 int'($signed(yaw)), arm);
                    m_arm <= arm;
                    age   <= 0;
                    m_cnt <= 0;
                    m_fs  <= 1'b0;
                    m_rdy <= 1'b0;
                end else if (m_arm) begin
                    if (m_cnt + 1 == TMO) begin
                        pend  <= mix(SMIN, 0, 0, 0, 1'b1);
                        age   <= 0;
                        m_cnt <= 0;
                        m_fs  <= 1'b1;
                        m_rdy <= 1'b0;
                    end else begin
                        m_cnt <= m_cnt + 1;
                    end
                end else begin
                    m_cnt <= 0;
                end
            end else if (age < 2) begin
                age <= age + 1;
            end else if (age == 2) begin
                if (pwm_busy == 4'b0000) begin
                    m_spd <= pend;
                    m_oe  <= 1'b1;
                    age   <= 3;
                end
            end else begin
                age   <= -1;
                m_rdy <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("speed_out0", int'(speed_out0), int'(m_spd[0]));
            check("speed_out1", int'(speed_out1), int'(m_spd[1]));
            check("speed_out2", int'(speed_out2), int'(m_spd[2]));
            check("speed_out3", int'(speed_out3), int'(m_spd[3]));
            check("speed_oe",   int'(speed_oe),   m_oe ? 15 : 0);
            check("cmd_ready",  int'(cmd_ready),  int'(m_rdy));
            check("failsafe",   int'(failsafe),   int'(m_fs));
        end
    end

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic send(input int t, input int r, input int p, input int y, input bit a);
        int n;
        throttle  = 16'(t);
        roll      = 16'(r);
        pitch     = 16'(p);
        yaw       = 16'(y);
        arm       = a;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n <= 400) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait_expired", int'(n > 400), 0);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_oe(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (speed_oe == 4'b0000 && lat < 400);
        check("oe_seen", int'(speed_oe), 15);
    endtask

    task automatic check_speeds(input string name, input int s0, input int s1, input int s2, input int s3);
        check({name, "_m0"}, int'(speed_out0), s0);
        check({name, "_m1"}, int'(speed_out1), s1);
        check({name, "_m2"}, int'(speed_out2), s2);
        check({name, "_m3"}, int'(speed_out3), s3);
    endtask

    initial begin
        int lat;
        int oe_cnt;

        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check("rst_speed0", int'(speed_out0), 0);
        check("rst_oe", int'(speed_oe), 0);
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_failsafe", int'(failsafe), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal mix and latency.
        send(30000, 1000, -500, 200, 1'b1);
        wait_oe(lat);
        check("nominal_latency", lat, 3);
        check_speeds("nominal", 30300, 28700, 29300, 31700);
        @(negedge clk);
        check("nominal_oe_width", int'(speed_oe), 0);
        check("nominal_ready_back", int'(cmd_ready), 1);

        // Ceiling and floor saturation.
        send(59000, 0, 2000, 0, 1'b1);
        wait_oe(lat);
        check_speeds("sat_hi", 60000, 60000, 57000, 57000);
        @(negedge clk);
        send(0, -5000, 0, 0, 1'b1);
        wait_oe(lat);
        check_speeds("sat_lo", 16384, 16384, 16384, 16384);
        @(negedge clk);

        // Disarm forces zero.
        send(40000, 0, 0, 0, 1'b0);
        wait_oe(lat);
        check_speeds("disarm", 0, 0, 0, 0);
        @(negedge clk);

        // Backpressure from one busy channel.
        pwm_busy = 4'b0100;
        send(30000, 1000, -500, 200, 1'b1);
        oe_cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (speed_oe != 4'b0000) oe_cnt++;
        end
        check("busy_no_oe", oe_cnt, 0);
        check_speeds("busy_hold", 0, 0, 0, 0);
        pwm_busy = 4'b0000;
        wait_oe(lat);
        check("busy_release_latency", lat, 1);
        check_speeds("busy_release", 30300, 28700, 29300, 31700);
        @(negedge clk);

        // Idle timeout fires the failsafe command; first idle negedge is idle cycle 1.
        wait_oe(lat);
        check("timeout_latency", lat, 103);
        check_speeds("failsafe", 16384, 16384, 16384, 16384);
        check("failsafe_set", int'(failsafe), 1);
        @(negedge clk);
        check("failsafe_held", int'(failsafe), 1);
        send(30000, 1000, -500, 200, 1'b1);
        check("failsafe_cleared", int'(failsafe), 0);
        wait_oe(lat);
        @(negedge clk);

        // Command arrives in the very cycle the watchdog would expire.
        repeat (99) @(negedge clk);
        send(59000, 0, 2000, 0, 1'b1);
        wait_oe(lat);
        check("prio_latency", lat, 3);
        check_speeds("prio", 60000, 60000, 57000, 57000);
        check("prio_no_failsafe", int'(failsafe), 0);
        @(negedge clk);

        // Reset while parked in WAIT.
        pwm_busy = 4'b0001;
        send(0, -5000, 0, 0, 1'b1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_speeds("midrst", 0, 0, 0, 0);
        check("midrst_oe", int'(speed_oe), 0);
        check("midrst_failsafe", int'(failsafe), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        pwm_busy = 4'b0000;
        @(negedge clk);
        check("midrst_ready", int'(cmd_ready), 1);
        oe_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (speed_oe != 4'b0000) oe_cnt++;
        end
        check("midrst_no_oe", oe_cnt, 0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
